// File: rtl/membus_arb_pkg.sv
// Shared types and helpers for the Membus N:1 arbiter.
//   onehot_from_idx : index -> one-hot vector (MaxMasters wide)
//   rr_pick         : first set request scanning from a start index, wrapping at n
// Callers size-cast the MaxMasters-wide vectors down to their own master count.
// NUM_MASTERS is limited to MaxMasters.
package membus_arb_pkg;

   localparam int unsigned MaxMasters = 32;
   localparam int unsigned MaxIdW     = 5;

   typedef logic [MaxMasters-1:0] req_vec_t;
   typedef logic [MaxIdW-1:0]     max_idx_t;

   function automatic req_vec_t onehot_from_idx(input max_idx_t idx);
      req_vec_t oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // start must be < n; the scan visits start, start+1, ... n-1, 0, ... start-1.
   function automatic void rr_pick(input  req_vec_t           req,
                                   input  logic [MaxIdW:0]    n,
                                   input  max_idx_t           start,
                                   output max_idx_t           idx,
                                   output logic               found);
      logic [MaxIdW:0] j;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < MaxMasters; k++) begin
         j = {1'b0, start} + (MaxIdW+1)'(k);
         if (j >= n) j = j - n;
         if (((MaxIdW+1)'(k) < n) && !found && req[j[MaxIdW-1:0]]) begin
            idx   = j[MaxIdW-1:0];
            found = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/id_fifo.sv
// Grant-ID FIFO holding the master index of every accepted, unanswered request.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   push_i, data_i  : enqueue an ID (allowed when full only together with pop_i)
//   pop_i, data_o   : dequeue; data_o is the current head
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries
module id_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CntW = $clog2(DEPTH+1);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/membus_rr_arbiter.sv
// N-master to 1-slave Membus arbiter with in-order response routing.
//   clk, rst (sync, active-low)
//   m_valid/m_ready/m_addr/m_wen/m_wdata/m_wmask : per-master request channel
//   m_rvalid/m_rdata : per-master response (rdata broadcast, qualified by rvalid)
//   s_valid/s_ready/s_addr/s_wen/s_wdata/s_wmask : request to slave
//   s_rvalid/s_rdata : slave response
//   busy : requests outstanding;  err_orphan : sticky response-without-request flag
// Macro MEMBUS_ARB_FIXED_PRIO_EN: fixed priority (index 0 highest) instead of round-robin.
module membus_rr_arbiter
   import membus_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ID_W            = $clog2(NUM_MASTERS)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_MASTERS-1:0]                  m_valid,
   output logic [NUM_MASTERS-1:0]                  m_ready,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
   input  logic [NUM_MASTERS-1:0]                  m_wen,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_wmask,
   output logic [NUM_MASTERS-1:0]                  m_rvalid,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_rdata,
   output logic                                    s_valid,
   output logic [ADDR_WIDTH-1:0]                   s_addr,
   output logic                                    s_wen,
   output logic [DATA_WIDTH-1:0]                   s_wdata,
   output logic [DATA_WIDTH/8-1:0]                 s_wmask,
   input  logic                                    s_ready,
   input  logic                                    s_rvalid,
   input  logic [DATA_WIDTH-1:0]                   s_rdata,
   output logic                                    busy,
   output logic                                    err_orphan
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING+1);
   typedef logic [ID_W-1:0] arb_id_t;

   logic      lock_valid_q, lock_valid_d;
   arb_id_t   lock_id_q, lock_id_d;
   logic      err_orphan_q, err_orphan_d;
   arb_id_t   grant, head;
   logic      req_active, can_issue, push, pop;
   logic      fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;
   max_idx_t  scan_start, pick_idx;
   logic      pick_found;

`ifdef MEMBUS_ARB_FIXED_PRIO_EN
   assign scan_start = '0;
`else
   arb_id_t rr_ptr_q, rr_ptr_d;
   assign scan_start = max_idx_t'(rr_ptr_q);
`endif

   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      rr_pick(req_vec_t'(m_valid), (MaxIdW+1)'(NUM_MASTERS), scan_start, pick_idx, pick_found);
   end

   // A stalled request keeps the bus until accepted, regardless of other requesters.
   assign grant      = lock_valid_q ? lock_id_q : arb_id_t'(pick_idx);
   assign req_active = lock_valid_q ? m_valid[lock_id_q] : pick_found;

   // A response in the same cycle frees a slot, so a full FIFO can still accept.
   assign pop       = rst && s_rvalid && !fifo_empty;
   assign can_issue = !fifo_full || pop;
   assign s_valid   = rst && req_active && can_issue;
   assign push      = s_valid && s_ready;

   assign s_addr  = m_addr[grant];
   assign s_wen   = m_wen[grant];
   assign s_wdata = m_wdata[grant];
   assign s_wmask = m_wmask[grant];

   assign m_ready  = (rst && s_ready && can_issue) ?
                     NUM_MASTERS'(onehot_from_idx(max_idx_t'(grant))) : '0;
   assign m_rvalid = pop ? NUM_MASTERS'(onehot_from_idx(max_idx_t'(head))) : '0;
   assign m_rdata  = {NUM_MASTERS{s_rdata}};

   assign busy       = (fifo_count != '0);
   assign err_orphan = err_orphan_q;

   always_comb begin
      lock_valid_d = 1'b0;
      lock_id_d    = lock_id_q;
      err_orphan_d = err_orphan_q | (s_rvalid & fifo_empty);
`ifndef MEMBUS_ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (grant == arb_id_t'(NUM_MASTERS-1)) ? '0 : grant + 1'b1;
      end
`endif
      if (s_valid && !s_ready) begin
         lock_valid_d = 1'b1;
         lock_id_d    = grant;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_valid_q <= 1'b0;
         lock_id_q    <= '0;
         err_orphan_q <= 1'b0;
`ifndef MEMBUS_ARB_FIXED_PRIO_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         err_orphan_q <= err_orphan_d;
`ifndef MEMBUS_ARB_FIXED_PRIO_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .data_i  (grant),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_membus_rr_arbiter.sv
// Directed self-checking bench for membus_rr_arbiter (N=2 main instance, N=3 priority instance).
module tb_membus_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // N=2 instance
   logic [1:0]        m_valid, m_ready, m_wen, m_rvalid;
   logic [1:0][63:0]  m_addr, m_wdata, m_rdata;
   logic [1:0][7:0]   m_wmask;
   logic              s_valid, s_wen, s_ready, s_rvalid, busy, err_orphan;
   logic [63:0]       s_addr, s_wdata, s_rdata;
   logic [7:0]        s_wmask;

   // N=3 instance
   logic [2:0]        m_valid3, m_ready3, m_wen3, m_rvalid3;
   logic [2:0][63:0]  m_addr3, m_wdata3, m_rdata3;
   logic [2:0][7:0]   m_wmask3;
   logic              s_valid3, s_wen3, s_ready3, s_rvalid3, busy3, err_orphan3;
   logic [63:0]       s_addr3, s_wdata3, s_rdata3;
   logic [7:0]        s_wmask3;

   membus_rr_arbiter #(
      .NUM_MASTERS (2), .DATA_WIDTH (64), .ADDR_WIDTH (64), .MAX_OUTSTANDING (4)
   ) u_dut (
      .clk (clk), .rst (rst),
      .m_valid (m_valid), .m_ready (m_ready), .m_addr (m_addr), .m_wen (m_wen),
      .m_wdata (m_wdata), .m_wmask (m_wmask), .m_rvalid (m_rvalid), .m_rdata (m_rdata),
      .s_valid (s_valid), .s_addr (s_addr), .s_wen (s_wen), .s_wdata (s_wdata),
      .s_wmask (s_wmask), .s_ready (s_ready), .s_rvalid (s_rvalid), .s_rdata (s_rdata),
      .busy (busy), .err_orphan (err_orphan)
   );

   membus_rr_arbiter #(
      .NUM_MASTERS (3), .DATA_WIDTH (64), .ADDR_WIDTH (64), .MAX_OUTSTANDING (4)
   ) u_dut3 (
      .clk (clk), .rst (rst),
      .m_valid (m_valid3), .m_ready (m_ready3), .m_addr (m_addr3), .m_wen (m_wen3),
      .m_wdata (m_wdata3), .m_wmask (m_wmask3), .m_rvalid (m_rvalid3), .m_rdata (m_rdata3),
      .s_valid (s_valid3), .s_addr (s_addr3), .s_wen (s_wen3), .s_wdata (s_wdata3),
      .s_wmask (s_wmask3), .s_ready (s_ready3), .s_rvalid (s_rvalid3), .s_rdata (s_rdata3),
      .busy (busy3), .err_orphan (err_orphan3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int g, prev;

   initial begin
      rst       = 1'b0;
      m_valid   = 2'b11;
      m_addr[0] = 64'h100;  m_addr[1] = 64'h200;
      m_wdata[0] = 64'hA0;  m_wdata[1] = 64'hA1;
      m_wen     = 2'b10;
      m_wmask[0] = 8'h0F;   m_wmask[1] = 8'hF0;
      s_ready   = 1'b1;
      s_rvalid  = 1'b0;
      s_rdata   = '0;
      m_valid3  = '0;
      for (int i = 0; i < 3; i++) begin
         m_addr3[i]  = 64'h30 + 64'(i);
         m_wdata3[i] = '0;
         m_wmask3[i] = '0;
      end
      m_wen3    = '0;
      s_ready3  = 1'b0;
      s_rvalid3 = 1'b0;
      s_rdata3  = '0;

      // Reset gating is combinational
      #2;
      check("rst_s_valid", 64'(s_valid), 64'd0);
      check("rst_m_ready", 64'(m_ready), 64'd0);
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_orphan), 64'd0);
      rst = 1'b1;

      // Both masters always valid, 1-cycle responses
      prev = 0;
      for (int c = 0; c < 4; c++) begin
         m_valid  = 2'b11;
         s_ready  = 1'b1;
         s_rvalid = (c > 0);
         s_rdata  = 64'hD000 + 64'(c);
         #1;
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = c % 2;
`endif
         check("alt_s_valid", 64'(s_valid), 64'd1);
         check("alt_s_addr", s_addr, (g == 0) ? 64'h100 : 64'h200);
         check("alt_s_wdata", s_wdata, (g == 0) ? 64'hA0 : 64'hA1);
         check("alt_m_ready", 64'(m_ready), 64'(1 << g));
         if (c > 0) begin
            check("alt_m_rvalid", 64'(m_rvalid), 64'(1 << prev));
            check("alt_m_rdata", m_rdata[prev], 64'hD000 + 64'(c));
         end
         prev = g;
         tick();
      end
      m_valid  = 2'b00;
      s_rvalid = 1'b1;
      #1;
      check("alt_drain_rvalid", 64'(m_rvalid), 64'(1 << prev));
      tick();
      s_rvalid = 1'b0;
      #1;
      check("alt_idle_busy", 64'(busy), 64'd0);

      // Stall lock: master1 holds the bus while master0 joins
      for (int c = 0; c < 4; c++) begin
         m_valid = (c >= 1) ? 2'b11 : 2'b10;
         s_ready = (c == 3);
         #1;
         check("lock_s_valid", 64'(s_valid), 64'd1);
         check("lock_s_addr", s_addr, 64'h200);
         check("lock_m_ready", 64'(m_ready), (c == 3) ? 64'd2 : 64'd0);
         tick();
      end
      m_valid = 2'b01;
      s_ready = 1'b1;
      #1;
      check("lock_next_addr", s_addr, 64'h100);
      check("lock_next_ready", 64'(m_ready), 64'd1);
      tick();
      m_valid  = 2'b00;
      s_rvalid = 1'b1;
      #1;
      check("lock_resp1", 64'(m_rvalid), 64'd2);
      tick();
      #1;
      check("lock_resp0", 64'(m_rvalid), 64'd1);
      tick();
      s_rvalid = 1'b0;

      // Outstanding limit with master0 alone
      m_valid = 2'b01;
      s_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("full_accept", 64'(m_ready), 64'd1);
         tick();
      end
      #1;
      check("full_s_valid", 64'(s_valid), 64'd0);
      check("full_m_ready", 64'(m_ready), 64'd0);
      check("full_busy", 64'(busy), 64'd1);
      tick();
      s_rvalid = 1'b1;
      #1;
      check("full_pp_s_valid", 64'(s_valid), 64'd1);
      check("full_pp_m_ready", 64'(m_ready), 64'd1);
      check("full_pp_rvalid", 64'(m_rvalid), 64'd1);
      tick();
      s_rvalid = 1'b0;
      #1;
      check("full_again", 64'(s_valid), 64'd0);
      m_valid  = 2'b00;
      s_rvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("full_drain", 64'(m_rvalid), 64'd1);
         tick();
      end
      s_rvalid = 1'b0;
      #1;
      check("full_idle", 64'(busy), 64'd0);

      // Orphan response
      s_rvalid = 1'b1;
      #1;
      check("orphan_rvalid", 64'(m_rvalid), 64'd0);
      tick();
      s_rvalid = 1'b0;
      #1;
      check("orphan_set", 64'(err_orphan), 64'd1);
      tick();
      tick();
      check("orphan_sticky", 64'(err_orphan), 64'd1);

      // Reset with 3 outstanding; round-robin pointer ends at 1 before it
      m_valid = 2'b01;
      s_ready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      rst      = 1'b0;
      m_valid  = 2'b11;
      s_rvalid = 1'b1;
      #1;
      check("mid_rst_s_valid", 64'(s_valid), 64'd0);
      check("mid_rst_m_ready", 64'(m_ready), 64'd0);
      check("mid_rst_m_rvalid", 64'(m_rvalid), 64'd0);
      tick();
      rst      = 1'b1;
      m_valid  = 2'b00;
      s_rvalid = 1'b0;
      #1;
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_err", 64'(err_orphan), 64'd0);
      s_rvalid = 1'b1;
      #1;
      check("stale_rvalid", 64'(m_rvalid), 64'd0);
      tick();
      s_rvalid = 1'b0;
      m_valid  = 2'b11;
      #1;
      check("stale_err", 64'(err_orphan), 64'd1);
      check("post_rst_grant", s_addr, 64'h100);
      check("post_rst_ready", 64'(m_ready), 64'd1);
      tick();
      m_valid  = 2'b00;
      s_rvalid = 1'b1;
      #1;
      check("post_rst_resp", 64'(m_rvalid), 64'd1);
      tick();
      s_rvalid = 1'b0;

      // Three masters, all valid
      m_valid3 = 3'b111;
      s_ready3 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = c;
`endif
         check("n3_m_ready", 64'(m_ready3), 64'(1 << g));
         check("n3_s_addr", s_addr3, 64'h30 + 64'(g));
         tick();
      end
      m_valid3 = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
